// File: rtl/gpu_scb_pkg.sv
// Shared types and constants for the Tom GPU/DSP register-hazard scoreboard.
package gpu_scb_pkg;

  localparam int unsigned REG_IDX_W    = 6;
  localparam int unsigned DefaultDepth = 4;
  localparam int unsigned DefaultLatW  = 3;
  // Entry counter storage width; LAT_W must not exceed this.
  localparam int unsigned CntMaxW      = 8;

  typedef struct packed {
    logic                 valid;
    logic [REG_IDX_W-1:0] idx;
    logic [CntMaxW-1:0]   cnt;
  } scb_entry_t;

  function automatic logic idx_hit(input logic en, input logic [REG_IDX_W-1:0] a,
                                   input logic [REG_IDX_W-1:0] b);
    return en && (a == b);
  endfunction

endpackage

// File: rtl/gpu_scb_entry.sv
// One pending-write slot: holds index and latency count, and reports RAW/WAW
// matches against the instruction at issue.
module gpu_scb_entry
  import gpu_scb_pkg::*;
#(
  parameter int unsigned LAT_W = DefaultLatW
) (
  input  logic                 clk_i,
  input  logic                 srst_ni,
  input  logic                 load_i,
  input  logic [REG_IDX_W-1:0] load_idx_i,
  input  logic [LAT_W-1:0]     load_lat_i,
  input  logic                 retire_i,
  input  logic                 srca_vld_i,
  input  logic [REG_IDX_W-1:0] srca_idx_i,
  input  logic                 srcb_vld_i,
  input  logic [REG_IDX_W-1:0] srcb_idx_i,
  input  logic                 issue_wr_i,
  input  logic [REG_IDX_W-1:0] issue_dst_i,
  output logic                 valid_o,
  output logic [REG_IDX_W-1:0] idx_o,
  output logic                 cnt_zero_o,
  output logic                 raw_a_o,
  output logic                 raw_b_o,
  output logic                 waw_o
);

  scb_entry_t entry_q, entry_d;

  // A load into a slot that is retiring the same cycle (full FIFO) wins.
  always_comb begin
    entry_d = entry_q;
    if (load_i) begin
      entry_d.valid = 1'b1;
      entry_d.idx   = load_idx_i;
      entry_d.cnt   = CntMaxW'(load_lat_i);
    end else if (retire_i) begin
      entry_d = '0;
    end else if (entry_q.valid && (entry_q.cnt != '0)) begin
      entry_d.cnt = entry_q.cnt - CntMaxW'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (!srst_ni) begin
      entry_q <= '0;
    end else begin
      entry_q <= entry_d;
    end
  end

  assign valid_o    = entry_q.valid;
  assign idx_o      = entry_q.idx;
  assign cnt_zero_o = (entry_q.cnt == '0);
  assign raw_a_o    = entry_q.valid & idx_hit(srca_vld_i, entry_q.idx, srca_idx_i);
  assign raw_b_o    = entry_q.valid & idx_hit(srcb_vld_i, entry_q.idx, srcb_idx_i);
  assign waw_o      = entry_q.valid & idx_hit(issue_wr_i, entry_q.idx, issue_dst_i);

endmodule

// File: rtl/gpu_scoreboard.sv
// Register-hazard scoreboard: in-order circular FIFO of pending destination writes.
// Optional same-cycle forwarding of the retiring head is enabled by SCB_BYPASS_EN.
module gpu_scoreboard
  import gpu_scb_pkg::*;
#(
  parameter int unsigned DEPTH = DefaultDepth,
  parameter int unsigned LAT_W = DefaultLatW
) (
  input  logic                 sys_clk,
  input  logic                 resetl,
  input  logic                 issue_vld,
  input  logic [REG_IDX_W-1:0] issue_dst,
  input  logic                 issue_wr,
  input  logic [LAT_W-1:0]     issue_lat,
  input  logic                 srca_vld,
  input  logic [REG_IDX_W-1:0] srca_idx,
  input  logic                 srcb_vld,
  input  logic [REG_IDX_W-1:0] srcb_idx,
  output logic                 issue_rdy,
  output logic                 stall,
  output logic                 full,
  output logic                 wb_vld,
  output logic [REG_IDX_W-1:0] wb_idx
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned OccW = $clog2(DEPTH + 1);

  logic [PtrW-1:0] head_q, head_d, tail_q, tail_d;
  logic [OccW-1:0] occ_q, occ_d;

  logic [DEPTH-1:0]     ent_valid, ent_zero, raw_a, raw_b, waw, load, retire, hit;
  logic [REG_IDX_W-1:0] ent_idx [DEPTH];
  logic                 push, pop, occ_full;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  for (genvar i = 0; i < DEPTH; i++) begin : g_entry
    assign load[i]   = push && (tail_q == PtrW'(i));
    assign retire[i] = pop && (head_q == PtrW'(i));

    gpu_scb_entry #(
      .LAT_W(LAT_W)
    ) u_entry (
      .clk_i      (sys_clk),
      .srst_ni    (resetl),
      .load_i     (load[i]),
      .load_idx_i (issue_dst),
      .load_lat_i (issue_lat),
      .retire_i   (retire[i]),
      .srca_vld_i (srca_vld),
      .srca_idx_i (srca_idx),
      .srcb_vld_i (srcb_vld),
      .srcb_idx_i (srcb_idx),
      .issue_wr_i (issue_wr),
      .issue_dst_i(issue_dst),
      .valid_o    (ent_valid[i]),
      .idx_o      (ent_idx[i]),
      .cnt_zero_o (ent_zero[i]),
      .raw_a_o    (raw_a[i]),
      .raw_b_o    (raw_b[i]),
      .waw_o      (waw[i])
    );
  end

  assign occ_full = (occ_q == OccW'(DEPTH));
  assign wb_vld   = resetl & ent_valid[head_q] & ent_zero[head_q];
  assign wb_idx   = wb_vld ? ent_idx[head_q] : '0;

  always_comb begin
    hit = raw_a | raw_b | waw;
`ifdef SCB_BYPASS_EN
    // The retiring head's result is forwarded, so it no longer blocks.
    if (wb_vld) begin
      hit[head_q] = 1'b0;
    end
`endif
  end

  assign stall = resetl & issue_vld & (|hit);
`ifdef SCB_BYPASS_EN
  assign full = resetl & occ_full & ~wb_vld;
`else
  assign full = resetl & occ_full;
`endif
  assign issue_rdy = resetl & issue_vld & ~stall & ~(full & issue_wr);

  assign push = issue_rdy & issue_wr;
  assign pop  = wb_vld;

  always_comb begin
    head_d = pop ? ptr_inc(head_q) : head_q;
    tail_d = push ? ptr_inc(tail_q) : tail_q;
    occ_d  = occ_q;
    unique case ({push, pop})
      2'b10:   occ_d = occ_q + OccW'(1);
      2'b01:   occ_d = occ_q - OccW'(1);
      default: occ_d = occ_q;
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (!resetl) begin
      head_q <= '0;
      tail_q <= '0;
      occ_q  <= '0;
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
      occ_q  <= occ_d;
    end
  end

endmodule

// File: doc/gpu_scoreboard.md
Name: gpu_scoreboard

Overview:
- Register-hazard scoreboard for the Tom GPU/DSP issue stage; sits directly upstream of the 6-bit index equality comparators.
- Holds up to DEPTH in-flight destination register indices (6 bits: bank bit plus 5-bit register number).
- Feeds each pending index and each operand index into per-entry equal/not-equal compares, then consumes the results to stall dependent instructions.
- Retires entries in issue order, one per cycle, and presents the retired index to the register-file write port.

Parameters:
DEPTH, 4, number of pending-write entries (2..8)
LAT_W, 3, width of per-entry latency counter

Ports:
sys_clk  in  1  system clock, all state on rising edge
resetl  in  1  synchronous active-low reset
issue_vld  in  1  instruction presented for issue
issue_dst  in  6  destination register index of presented instruction
issue_wr  in  1  presented instruction writes a register
issue_lat  in  LAT_W  cycles until result is ready (0 = next cycle)
srca_vld  in  1  operand A index is used
srca_idx  in  6  operand A register index
srcb_vld  in  1  operand B index is used
srcb_idx  in  6  operand B register index
issue_rdy  out  1  presented instruction accepted this cycle
stall  out  1  hazard detected
full  out  1  all DEPTH entries occupied
wb_vld  out  1  head entry retiring this cycle
wb_idx  out  6  index being retired

Behaviour:
- Reset (resetl=0 at clock edge): all entries invalid, counters 0, head/tail pointers 0. Outputs issue_rdy=0, stall=0, full=0, wb_vld=0, wb_idx=0. Reset mid-operation discards pending entries with no wb_vld.
- Entry contents: valid, idx[5:0], cnt[LAT_W-1:0]. Organised as a circular FIFO: head = oldest, tail = next free; occupancy counter 0..DEPTH.
- Hazard match (combinational): for each valid entry, RAW_A = srca_vld & (idx==srca_idx); RAW_B = srcb_vld & (idx==srcb_idx); WAW = issue_wr & (idx==issue_dst). All compares are full 6-bit equality, so bank 0 and bank 1 never alias.
- stall = issue_vld & (any RAW_A | RAW_B | WAW over valid entries).
- issue_rdy = issue_vld & ~stall & ~(full & issue_wr). Instructions with issue_wr=0 are never blocked by full.
- On issue_rdy & issue_wr: the tail entry is loaded with idx=issue_dst and cnt=issue_lat, and tail advances.
- Counters: each valid entry with cnt≠0 decrements by 1 per cycle. Non-head entries saturate at 0.
- Retire: wb_vld=1 when the head is valid and its cnt==0. wb_idx is the head idx, driven combinationally, with zero added latency. The head is invalidated at that edge. Strictly in order: a younger entry at 0 waits behind an older one.
- Simultaneous retire and issue in the same cycle: both occur. Occupancy is unchanged; a full FIFO accepts the issue only if the SCB_BYPASS_EN path (below) permits it. Without the macro, full is evaluated before the retire.
- Pointer wrap: modulo DEPTH. Occupancy never exceeds DEPTH and never underflows.
- A retiring entry still counts for stall in its retire cycle (without the macro).

Optional Feature:
SCB_BYPASS_EN
- Defined:
  - The head entry with wb_vld=1 is excluded from the RAW/WAW match in that cycle, because the result is forwarded.
  - full is computed as occupancy==DEPTH & ~wb_vld, so issue into the freed slot happens in the same cycle.
- Undefined: the conservative behaviour above, costing one extra bubble per dependency.

Decomposition:
- Shared package gpu_scb_pkg holds:
  - constant REG_IDX_W=6
  - typedef scb_entry_t {valid, idx, cnt}
  - default DEPTH and LAT_W constants
- One natural sub-module, gpu_scb_entry: holds a single entry's register, decrement/saturate logic, and the three 6-bit match outputs. It is instantiated DEPTH times.

Test Plan:
- Reset: hold resetl=0 with issue_vld=1 → issue_rdy=0, wb_vld=0, stall=0. Release → first issue of dst=0x05, lat=2 accepted.
- RAW: issue dst=0x05, lat=2; next cycle srca_idx=0x05 → stall=1 for 2 cycles. wb_vld with wb_idx=0x05 on the 3rd cycle. Without the macro, stall clears the cycle after wb_vld; with SCB_BYPASS_EN, it clears in the wb cycle.
- Bank separation: pending 0x05; issue with srcb_idx=0x25 → no stall, accepted.
- In-order retire: issue dst=0x01 lat=3, then dst=0x02 lat=0 → wb_idx 0x01 then 0x02 on consecutive cycles. 0x02 is never retired first.
- Full: DEPTH=4; issue four writes lat=7 → full=1. Fifth writing issue → issue_rdy=0. A non-writing instruction with no hazard → issue_rdy=1.
- WAW plus wrap: pending 0x10; issue dst=0x10 → stall until retired. Then ten issue/retire pairs → pointers wrap with correct wb order and no spurious wb_vld.
